// File: rtl/oled_fb_streamer_if.sv
// Command channel between the framebuffer streamer and the SSD1331 driver:
// one set-pixel command at a time on a strobe/ready handshake.
interface oled_fb_streamer_if;
  logic [7:0]  x_dc;
  logic [7:0]  y_data;
  logic [15:0] rgb;
  logic        strobe;
  logic        setpixel_raw8tx;
  logic        ready;

  modport master (
    output x_dc,
    output y_data,
    output rgb,
    output strobe,
    output setpixel_raw8tx,
    input  ready
  );

  modport slave (
    input  x_dc,
    input  y_data,
    input  rgb,
    input  strobe,
    input  setpixel_raw8tx,
    output ready
  );
endinterface

// File: rtl/oled_fb_streamer.sv
// Streams an RGB565 framebuffer to the SSD1331 driver in raster order, one
// set-pixel command per pixel: FETCH (RAM read) -> LOAD (capture) -> SEND.
module oled_fb_streamer #(
  parameter int WIDTH  = 96,
  parameter int HEIGHT = 64,
  parameter int ADDR_W = 13
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                enable,
  output logic                fb_rd_en,
  output logic [ADDR_W-1:0]   fb_addr,
  input  logic [15:0]         fb_data,
  oled_fb_streamer_if.master  drv,
  output logic                busy,
  output logic                frame_done,
  output logic [7:0]          frame_count
);

  if (WIDTH < 1 || WIDTH > 256 || HEIGHT < 1 || HEIGHT > 256 ||
      WIDTH * HEIGHT > (1 << ADDR_W)) begin : g_bad_geometry
    $error("oled_fb_streamer: geometry does not fit coordinates or address");
  end

  localparam logic [7:0]        X_LAST = 8'(WIDTH - 1);
  localparam logic [7:0]        Y_LAST = 8'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(WIDTH * HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, SEND} state_t;

  state_t            state_q;
  state_t            state_d;

  logic [7:0]        x_p0;
  logic [7:0]        y_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [7:0]        x_dc_p1;
  logic [7:0]        y_data_p1;
  logic [15:0]       rgb_p1;
  logic              vld_p1;
  logic              frame_done_q;
  logic [7:0]        frame_count_q;

  logic              accept;
  logic              last_px;

  function automatic logic [7:0] step_coord(input logic [7:0] v,
                                            input logic [7:0] last);
    return (v == last) ? 8'd0 : v + 8'd1;
  endfunction

  function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] v);
    return (v == A_LAST) ? '0 : v + 1'b1;
  endfunction

  assign accept  = vld_p1 && drv.ready;
  assign last_px = (x_p0 == X_LAST) && (y_p0 == Y_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // enable only matters when starting from IDLE and at the end of a frame,
  // so a mid-frame deassertion always lets the current frame finish.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = FETCH;
      FETCH:   state_d = LOAD;
      LOAD:    state_d = SEND;
      SEND:    if (drv.ready) state_d = (last_px && !enable) ? IDLE : FETCH;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fb_rd_en = (state_q == FETCH);
    vld_p1   = (state_q == SEND);
    busy     = (state_q != IDLE);
  end

  // Stage 0: raster position and running RAM address of the pixel in flight
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_p0    <= '0;
      y_p0    <= '0;
      addr_p0 <= '0;
    end else if (state_q == IDLE && enable) begin
      x_p0    <= '0;
      y_p0    <= '0;
      addr_p0 <= '0;
    end else if (accept) begin
      x_p0    <= step_coord(x_p0, X_LAST);
      addr_p0 <= step_addr(addr_p0);
      if (x_p0 == X_LAST) begin
        y_p0 <= step_coord(y_p0, Y_LAST);
      end
    end
  end

  // Stage 1: command register, held until the driver accepts it
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_dc_p1   <= '0;
      y_data_p1 <= '0;
      rgb_p1    <= '0;
    end else if (state_q == LOAD) begin
      x_dc_p1   <= x_p0;
      y_data_p1 <= y_p0;
      rgb_p1    <= fb_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      frame_done_q <= accept && last_px;
      if (accept && last_px) begin
        frame_count_q <= frame_count_q + 8'd1;
      end
    end
  end

  assign fb_addr             = addr_p0;
  assign drv.x_dc            = x_dc_p1;
  assign drv.y_data          = y_data_p1;
  assign drv.rgb             = rgb_p1;
  assign drv.strobe          = vld_p1;
  assign drv.setpixel_raw8tx = 1'b0;
  assign frame_done          = frame_done_q;
  assign frame_count         = frame_count_q;

endmodule

// File: tb/tb_oled_fb_streamer.sv
// Bench for oled_fb_streamer: a 96x8 instance for streaming behaviour and a
// 2x1 instance for the frame counter wrap, both against a raster-order model.
module tb_oled_fb_streamer;
  localparam int WA = 96;
  localparam int HA = 8;
  localparam int NA = WA * HA;
  localparam int WB = 2;
  localparam int HB = 1;
  localparam int NB = WB * HB;
  localparam int LIMIT = 20000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        enable_a, enable_b;
  logic        fb_rd_en_a, fb_rd_en_b;
  logic [12:0] fb_addr_a;
  logic [0:0]  fb_addr_b;
  logic [15:0] fb_data_a, fb_data_b;
  logic        busy_a, busy_b;
  logic        frame_done_a, frame_done_b;
  logic [7:0]  frame_count_a, frame_count_b;

  oled_fb_streamer_if if_a ();
  oled_fb_streamer_if if_b ();

  oled_fb_streamer #(.WIDTH(WA), .HEIGHT(HA), .ADDR_W(13)) u_dut_a (
    .clk(clk), .resetn(resetn), .enable(enable_a),
    .fb_rd_en(fb_rd_en_a), .fb_addr(fb_addr_a), .fb_data(fb_data_a),
    .drv(if_a), .busy(busy_a), .frame_done(frame_done_a),
    .frame_count(frame_count_a)
  );

  oled_fb_streamer #(.WIDTH(WB), .HEIGHT(HB), .ADDR_W(1)) u_dut_b (
    .clk(clk), .resetn(resetn), .enable(enable_b),
    .fb_rd_en(fb_rd_en_b), .fb_addr(fb_addr_b), .fb_data(fb_data_b),
    .drv(if_b), .busy(busy_b), .frame_done(frame_done_b),
    .frame_count(frame_count_b)
  );

  logic [15:0] mem_a [8192];
  logic [15:0] mem_b [2];

  // Synchronous-read RAMs; the data bus carries junk whenever no read was issued.
  always @(posedge clk) begin
    if (fb_rd_en_a) fb_data_a <= mem_a[fb_addr_a];
    else            fb_data_a <= 16'($urandom);
    if (fb_rd_en_b) fb_data_b <= mem_b[fb_addr_b];
    else            fb_data_b <= 16'($urandom);
  end

  int checks = 0;
  int errors = 0;
  bit rdy_rand = 1'b0;
  bit rdy_hold = 1'b1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial begin
    if_a.ready = 1'b1;
    if_b.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if_a.ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_hold;
      if_b.ready = ($urandom_range(0, 2) != 0);
    end
  end

  // Model: commands are pixels 0..N-1 in raster order, x = n % W, y = n / W,
  // rgb = RAM[n]; frame_done and the count bump come one cycle after the last
  // acceptance; a frame takes 3 cycles per pixel plus one per stalled cycle.
  int          exp_idx   [2] = '{0, 0};
  bit          pend      [2] = '{0, 0};
  logic [7:0]  exp_fc    [2] = '{8'd0, 8'd0};
  bit          prev_wait [2] = '{0, 0};
  logic [31:0] prev_cmd  [2] = '{32'd0, 32'd0};
  int          fcyc      [2] = '{0, 0};
  int          stalls    [2] = '{0, 0};

  task automatic mon(input int d, input logic rst_n, input logic rd,
                     input int addr, input logic strb, input logic rdy,
                     input logic [7:0] x, input logic [7:0] y,
                     input logic [15:0] rgb, input logic setpx,
                     input logic bsy, input logic fd, input logic [7:0] fc);
    int n, w;
    logic [15:0] exp_rgb;
    string p;
    n = (d == 0) ? NA : NB;
    w = (d == 0) ? WA : WB;
    p = (d == 0) ? "a" : "b";
    if (!rst_n) begin
      chk({p, "_reset_flags"}, {rd, strb, bsy, fd}, 0);
      chk({p, "_reset_cmd"}, {x, y, rgb, fc}, 0);
      chk({p, "_reset_addr"}, addr, 0);
      exp_idx[d] = 0; pend[d] = 0; exp_fc[d] = 8'd0; prev_wait[d] = 0;
      return;
    end
    if (pend[d]) exp_fc[d] = exp_fc[d] + 8'd1;
    chk({p, "_frame_done"}, fd, pend[d]);
    chk({p, "_frame_count"}, fc, exp_fc[d]);
    pend[d] = 0;
    chk({p, "_setpixel_mode"}, setpx, 0);
    chk({p, "_rd_while_strobe"}, rd && strb, 0);
    if (rd || strb) chk({p, "_busy"}, bsy, 1);
    if (rd) begin
      chk({p, "_fetch_addr"}, addr, exp_idx[d]);
      if (exp_idx[d] == 0) begin
        fcyc[d] = 0;
        stalls[d] = 0;
      end
    end
    fcyc[d]++;
    if (prev_wait[d]) begin
      chk({p, "_strobe_held"}, strb, 1);
      chk({p, "_cmd_stable"}, {x, y, rgb}, prev_cmd[d]);
    end
    if (strb) begin
      if (!rdy) begin
        stalls[d]++;
      end else begin
        exp_rgb = (d == 0) ? mem_a[13'(exp_idx[d])] : mem_b[1'(exp_idx[d])];
        chk({p, "_x_dc"}, x, exp_idx[d] % w);
        chk({p, "_y_data"}, y, exp_idx[d] / w);
        chk({p, "_rgb"}, rgb, exp_rgb);
        if (exp_idx[d] == n - 1) begin
          chk({p, "_frame_cycles"}, fcyc[d], 3 * n + stalls[d]);
          pend[d] = 1;
          exp_idx[d] = 0;
        end else begin
          exp_idx[d]++;
        end
      end
    end
    prev_wait[d] = strb && !rdy;
    prev_cmd[d]  = {x, y, rgb};
  endtask

  initial begin
    forever begin
      @(negedge clk);
      mon(0, resetn, fb_rd_en_a, int'(fb_addr_a), if_a.strobe, if_a.ready,
          if_a.x_dc, if_a.y_data, if_a.rgb, if_a.setpixel_raw8tx,
          busy_a, frame_done_a, frame_count_a);
      mon(1, resetn, fb_rd_en_b, int'(fb_addr_b), if_b.strobe, if_b.ready,
          if_b.x_dc, if_b.y_data, if_b.rgb, if_b.setpixel_raw8tx,
          busy_b, frame_done_b, frame_count_b);
    end
  end

  task automatic wait_fetch(input int a, input string nm);
    int i;
    for (i = 0; i < LIMIT; i++) begin
      @(negedge clk);
      if (fb_rd_en_a && int'(fb_addr_a) == a) break;
    end
    chk({nm, "_reached"}, i < LIMIT, 1);
  endtask

  task automatic wait_done(input int d, input string nm);
    int i;
    for (i = 0; i < LIMIT; i++) begin
      @(negedge clk);
      if ((d == 0) ? frame_done_a : frame_done_b) break;
    end
    chk({nm, "_frame_done_seen"}, i < LIMIT, 1);
  endtask

  task automatic count_reads(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (fb_rd_en_a) cnt++;
    end
  endtask

  initial begin
    int cyc;
    int rd_cnt;
    logic [7:0] fc0;

    resetn = 1'b0;
    enable_a = 1'b0;
    enable_b = 1'b0;
    for (int i = 0; i < 8192; i++) mem_a[i] = 16'(i);
    mem_b[0] = 16'($urandom);
    mem_b[1] = 16'($urandom);
    repeat (3) @(negedge clk);
    #1 resetn = 1'b1;

    // Single frame, data = address, ready tied high, one-cycle enable pulse
    @(posedge clk); #1 enable_a = 1'b1;
    @(posedge clk); #1 enable_a = 1'b0;
    @(negedge clk);
    chk("lat_fetch_rd", fb_rd_en_a, 1);
    chk("lat_fetch_addr", fb_addr_a, 0);
    @(negedge clk);
    chk("lat_load_strobe", if_a.strobe, 0);
    @(negedge clk);
    chk("lat_send_strobe", if_a.strobe, 1);
    chk("first_cmd", {if_a.x_dc, if_a.y_data, if_a.rgb}, 0);
    cyc = 3;
    while (!frame_done_a && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    chk("single_frame_cycles", cyc - 1, 2304);
    chk("single_frame_count", frame_count_a, 1);
    chk("single_busy_after", busy_a, 0);
    count_reads(10, rd_cnt);
    chk("single_idle_reads", rd_cnt, 0);

    // Backpressure on pixel (10,3)
    @(posedge clk); #1 enable_a = 1'b1;
    @(posedge clk); #1 enable_a = 1'b0;
    wait_fetch(3 * WA + 10, "bp_fetch");
    rdy_hold = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("bp_strobe", if_a.strobe, 1);
      chk("bp_cmd", {if_a.x_dc, if_a.y_data, if_a.rgb}, {8'd10, 8'd3, 16'd298});
      if (i == 4) rdy_hold = 1'b1;
    end
    @(negedge clk);
    chk("bp_next_fetch", {fb_rd_en_a, fb_addr_a}, {1'b1, 13'd299});
    rdy_rand = 1'b1;
    wait_done(0, "bp");
    rdy_rand = 1'b0;
    chk("bp_frame_count", frame_count_a, 2);

    // Continuous frames with random data, then disable at (40,5)
    for (int i = 0; i < NA; i++) mem_a[i] = 16'($urandom);
    fc0 = frame_count_a;
    #1 enable_a = 1'b1;
    rdy_rand = 1'b1;
    for (int f = 1; f <= 2; f++) begin
      wait_done(0, "cont");
      chk("cont_frame_count", frame_count_a, 8'(fc0 + 8'(f)));
      chk("cont_refetch", {fb_rd_en_a, fb_addr_a}, {1'b1, 13'd0});
    end
    wait_fetch(5 * WA + 40, "dis_fetch");
    #1 enable_a = 1'b0;
    wait_done(0, "dis");
    chk("dis_frame_count", frame_count_a, 8'(fc0 + 8'd3));
    chk("dis_busy", busy_a, 0);
    count_reads(20, rd_cnt);
    chk("dis_no_reads", rd_cnt, 0);

    // Asynchronous reset in the middle of pixel (50,6)
    @(posedge clk); #1 enable_a = 1'b1;
    wait_fetch(6 * WA + 50, "rst_fetch");
    @(posedge clk); #2 resetn = 1'b0;
    #1;
    chk("rst_flags", {fb_rd_en_a, if_a.strobe, busy_a, frame_done_a}, 0);
    chk("rst_count", frame_count_a, 0);
    chk("rst_cmd", {if_a.x_dc, if_a.y_data, if_a.rgb}, 0);
    chk("rst_addr", fb_addr_a, 0);
    repeat (2) @(negedge clk);
    #1 resetn = 1'b1;
    cyc = 0;
    while (!if_a.strobe && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_restart_xy", {if_a.x_dc, if_a.y_data, if_a.rgb}, {16'd0, mem_a[0]});
    chk("rst_restart_count", frame_count_a, 0);
    #1 enable_a = 1'b0;
    wait_done(0, "rst");
    chk("rst_frame_count", frame_count_a, 1);
    rdy_rand = 1'b0;

    // Frame counter wrap on the 2x1 instance
    @(posedge clk); #1 enable_b = 1'b1;
    for (int f = 1; f <= 257; f++) begin
      wait_done(1, "wrap");
      if (f == 255) chk("wrap_255", frame_count_b, 255);
      if (f == 256) begin
        chk("wrap_to_0", frame_count_b, 0);
        #1 enable_b = 1'b0;
      end
    end
    chk("wrap_after", frame_count_b, 1);
    chk("wrap_busy", busy_b, 0);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/oled_fb_streamer.md
# oled_fb_streamer

Upstream feeder for the SSD1331 OLED driver. It reads RGB565 pixels from a synchronous-read framebuffer RAM and presents them one at a time as set-pixel commands (`x_dc`, `y_data`, `rgb`) on the driver's `strobe`/`ready` handshake, raster order. It takes over the role of the free-running pattern generator, so the panel shows memory contents that other logic writes through the RAM's second port.

## Interface
- `WIDTH`, default 96: pixels per line.
- `HEIGHT`, default 64: lines per frame.
- `ADDR_W`, default 13: framebuffer address width. Must satisfy WIDTH*HEIGHT ≤ 2^ADDR_W.
- `clk` in 1: single clock. All logic is rising-edge.
- `resetn` in 1: asynchronous, active-low reset.
- `enable` in 1: level. While high, frames stream back-to-back.
- `fb_rd_en` out 1: framebuffer read strobe.
- `fb_addr` out ADDR_W: framebuffer read address, y*WIDTH + x.
- `fb_data` in 16: RGB565 read data. Valid the cycle after `fb_rd_en`.
- `x_dc` out 8: pixel column to the driver.
- `y_data` out 8: pixel row to the driver.
- `rgb` out 16: pixel colour to the driver.
- `strobe` out 1: command valid to the driver.
- `setpixel_raw8tx` out 1: constant 0, which selects set-pixel mode.
- `ready` in 1: driver accepts a command when `strobe` and `ready` are both high at a rising edge.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `frame_done` out 1: one-cycle pulse after the last pixel of a frame is accepted.
- `frame_count` out 8: completed-frame counter. Wraps 255→0.

## Operation
- FSM states: IDLE, FETCH, LOAD, SEND.
- IDLE → FETCH on an edge with `enable`=1. Coordinates and address are (0,0)/0.
- FETCH: `fb_rd_en`=1, `fb_addr`=current address. Always → LOAD next edge.
- LOAD: on the edge leaving LOAD, register `rgb`←`fb_data`, `x_dc`←x, `y_data`←y. → SEND.
- SEND: `strobe`=1. Stay in SEND until `ready` is sampled high.
  - While waiting, `x_dc`, `y_data` and `rgb` are held stable.
  - On the accepting edge, advance the position.
  - Not the last pixel: → FETCH.
  - Last pixel (WIDTH-1, HEIGHT-1): pulse `frame_done`, increment `frame_count`, then → FETCH if `enable`=1, else → IDLE.
- Position advance:
  - x increments; at WIDTH-1, x→0 and y increments.
  - At (WIDTH-1, HEIGHT-1), x,y→0,0.
  - The address is a separate running counter: +1 per pixel, 0 after WIDTH*HEIGHT-1. No multiplier.
- `enable` is sampled only in IDLE and at end of frame. Deassertion mid-frame completes the current frame, then the FSM idles.
- `strobe` is never deasserted before acceptance. `fb_rd_en` is never high outside FETCH.

## Timing
- Reset (asynchronous, immediate):
  - All outputs 0: `strobe`, `fb_rd_en`, `busy`, `frame_done`, `frame_count`, `x_dc`, `y_data`, `rgb`, `fb_addr`.
  - State → IDLE.
  - Reset mid-frame abandons the frame; no `frame_done` pulse.
- Latency: `enable` sampled high at edge E0 → FETCH during cycle E0+1 → `strobe` first high during cycle E0+3.
- Throughput with `ready` held high: 3 cycles per pixel, WIDTH*HEIGHT*3 cycles per frame (18432 at defaults).
- Each cycle that `ready` is low in SEND adds one cycle.
- `frame_done` is high in the cycle following the accepting edge of pixel (WIDTH-1, HEIGHT-1), concurrent with the `frame_count` update.
- `busy` falls one cycle after the final acceptance when `enable`=0.

## Test plan
- Single frame:
  - Stimulus: RAM preloaded with data = address; `ready` tied 1; `enable` pulsed high for one cycle.
  - Required: 6144 commands. Command n has `x_dc`=n%96, `y_data`=n/96, `rgb`=n. Exactly one `frame_done`. `frame_count`=1. `busy`=0 afterwards. 18432 cycles from first FETCH to last acceptance.
- Backpressure:
  - Stimulus: `ready` low for 5 cycles during pixel (10,3).
  - Required: `strobe` stays high and `x_dc`=10, `y_data`=3, `rgb`=298 stay stable for 6 SEND cycles. The next pixel is (11,3). No pixel is skipped or duplicated.
- Continuous mode:
  - Stimulus: `enable` held high for 3 frames.
  - Required: pixel (0,0) FETCH immediately follows the (95,63) acceptance. `frame_count` steps 1,2,3. Each frame ends with one `frame_done`.
- Mid-frame disable:
  - Stimulus: `enable` dropped at pixel (40,20).
  - Required: the frame completes to (95,63), then IDLE. No further `fb_rd_en`.
- Async reset mid-frame:
  - Stimulus: `resetn` low between edges at pixel (50,30).
  - Required: all outputs 0 immediately, no `frame_done`. After release with `enable`=1, streaming restarts at (0,0), address 0.
- Counter wrap:
  - Stimulus: `frame_count` forced to 255 via 255 frames, or with HEIGHT=1, WIDTH=2 for speed.
  - Required: the next `frame_done` sets `frame_count`=0.
